// File: rtl/fx_narrow_sat.sv
// Pipelined fixed-point narrowing converter: round-half-up on dropped fraction
// bits, saturate on dropped integer bits, with a valid/ready pipeline and saturation status.
module fx_narrow_sat #(
  parameter int IN_W     = 16,
  parameter int IN_FRAC  = 4,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_sat,
  input  logic             i_clr,
  output logic             o_sat_flag,
  output logic [CNT_W-1:0] o_sat_cnt
);

  localparam int D    = IN_FRAC - OUT_FRAC;
  localparam int R_W  = IN_W + 1 - D;       // rounded width; always >= OUT_W+1
  localparam int HI_W = R_W - OUT_W + 1;    // sign bit of the output plus all dropped MSBs

  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (IN_FRAC < OUT_FRAC || (IN_W - IN_FRAC) < (OUT_W - OUT_FRAC) || OUT_W < 2) begin : g_bad_params
    $error("fx_narrow_sat: illegal parameter set");
  end

  // ---------------- stage 1: round ----------------
  logic [IN_W:0]  ext;
  logic [R_W-1:0] rnd;

  assign ext = {i_data[IN_W-1], i_data};

  if (D > 0) begin : g_round
    localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (D - 1);
    logic [IN_W:0] sum;
    logic          unused_frac;
    // One extra MSB of headroom means adding the half-LSB can never wrap.
    assign sum         = ext + HALF;
    assign rnd         = sum[IN_W:D];
    assign unused_frac = ^sum[D-1:0];
  end else begin : g_pass
    assign rnd = ext;
  end

  // ---------------- handshake ----------------
  logic           s1_valid, s2_valid;
  logic [R_W-1:0] s1_r;
  logic           s1_moves, s1_load;

  assign s1_moves = s1_valid && (!s2_valid || o_ready);
  assign i_ready  = !s1_valid || s1_moves;
  assign s1_load  = i_valid && i_ready;

  // ---------------- stage 2: saturate ----------------
  logic [HI_W-1:0]  hi;
  logic             ovf;
  logic [OUT_W-1:0] sat_data;

  // In range exactly when every dropped MSB matches the output sign bit.
  assign hi  = s1_r[R_W-1:OUT_W-1];
  assign ovf = !((&hi) || !(|hi));

  always_comb begin
    // NOTE: default first so every path assigns sat_data and no latch is inferred.
    sat_data = s1_r[OUT_W-1:0];
    if (ovf) sat_data = s1_r[R_W-1] ? SAT_NEG : SAT_POS;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s2_valid <= 1'b0;
      o_data   <= '0;
      o_sat    <= 1'b0;
    end else begin
      if (s1_load)       s1_valid <= 1'b1;
      else if (s1_moves) s1_valid <= 1'b0;
      if (s1_load)       s1_r     <= rnd;

      if (s1_moves) begin
        s2_valid <= 1'b1;
        o_data   <= sat_data;
        o_sat    <= ovf;
      end else if (s2_valid && o_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign o_valid = s2_valid;

  // ---------------- saturation status ----------------
  logic sat_evt;
  assign sat_evt = s2_valid && o_ready && o_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sat_flag <= 1'b0;
      o_sat_cnt  <= '0;
    end else if (i_clr) begin
      // A saturation delivered in the clearing cycle is the first event after the clear.
      o_sat_flag <= sat_evt;
      o_sat_cnt  <= sat_evt ? CNT_ONE : '0;
    end else if (sat_evt) begin
      o_sat_flag <= 1'b1;
      if (o_sat_cnt != CNT_MAX) o_sat_cnt <= o_sat_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fx_narrow_sat.sv
// Directed bench for fx_narrow_sat: scoreboard of expected outputs, plus
// a CNT_W=2 twin sharing the same stimulus for the counter ceiling.
`timescale 1ns/1ps
module tb_fx_narrow_sat;

  localparam int IN_W = 16, IN_FRAC = 4, OUT_W = 12, OUT_FRAC = 2;
  localparam int D = IN_FRAC - OUT_FRAC;

  logic             clk, rst_n;
  logic [IN_W-1:0]  i_data;
  logic             i_valid, i_ready, o_valid, o_ready, o_sat, i_clr, o_sat_flag;
  logic [OUT_W-1:0] o_data;
  logic [15:0]      o_sat_cnt;
  logic             i_ready2, o_valid2, o_sat2, o_sat_flag2;
  logic [OUT_W-1:0] o_data2;
  logic [1:0]       o_sat_cnt2;

  typedef struct { logic [OUT_W-1:0] data; logic sat; } exp_t;
  exp_t sb_q[$];
  int   chk_cnt = 0, pass_cnt = 0, out_cnt = 0;

  fx_narrow_sat u_dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_sat(o_sat),
    .i_clr(i_clr), .o_sat_flag(o_sat_flag), .o_sat_cnt(o_sat_cnt)
  );

  fx_narrow_sat #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready2),
    .o_data(o_data2), .o_valid(o_valid2), .o_ready(o_ready), .o_sat(o_sat2),
    .i_clr(i_clr), .o_sat_flag(o_sat_flag2), .o_sat_cnt(o_sat_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: integer arithmetic rounding then clamp to the output range.
  function automatic exp_t model(input logic [IN_W-1:0] din);
    int   v, r;
    exp_t e;
    v = int'($signed(din));
    r = (v + (1 << (D - 1))) >>> D;
    if (r > 2047)       begin e.data = 12'h7FF;  e.sat = 1'b1; end
    else if (r < -2048) begin e.data = 12'h800;  e.sat = 1'b1; end
    else                begin e.data = 12'(r);   e.sat = 1'b0; end
    return e;
  endfunction

  // Inputs change just after posedge, so values seen at negedge hold through the next edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (o_valid && o_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) check("spurious_out", {31'd0, o_valid}, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("out_data", {20'd0, o_data}, {20'd0, e.data});
          check("out_sat", {31'd0, o_sat}, {31'd0, e.sat});
        end
      end
      if (i_valid && i_ready) sb_q.push_back(model(i_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d);
    int n;
    n = 0;
    i_data  = d;
    i_valid = 1'b1;
    #1;
    while (!i_ready && n < 50) begin
      step();
      #1;
      n++;
    end
    check("accept_timeout", {31'd0, i_ready}, 32'd1);
    step();
    i_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check(tag, sb_q.size(), 32'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b1; i_clr = 1'b0;
    #12;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_data", {20'd0, o_data}, 32'd0);
    check("rst_o_sat", {31'd0, o_sat}, 32'd0);
    check("rst_i_ready", {31'd0, i_ready}, 32'd1);
    check("rst_flag", {31'd0, o_sat_flag}, 32'd0);
    check("rst_cnt", {16'd0, o_sat_cnt}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Latency: sample presented, accepted at the next edge, visible after the one after.
    i_data = 16'h0006; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    check("lat_edge1_valid", {31'd0, o_valid}, 32'd0);
    step();
    check("lat_edge2_valid", {31'd0, o_valid}, 32'd1);
    check("lat_edge2_data", {20'd0, o_data}, 32'h002);
    send(16'h0005); send(16'hFFFB); send(16'h1FF9);
    drain("drain_basic");
    check("basic_cnt", {16'd0, o_sat_cnt}, 32'd0);
    check("basic_flag", {31'd0, o_sat_flag}, 32'd0);

    // Boundary saturation, including overflow caused only by rounding.
    send(16'h1FFE); send(16'h7FFF); send(16'h8000);
    drain("drain_sat");
    check("sat_flag", {31'd0, o_sat_flag}, 32'd1);
    check("sat_cnt3", {16'd0, o_sat_cnt}, 32'd3);

    // Counter ceiling on the 2-bit twin.
    send(16'h7FFF); send(16'h8000);
    drain("drain_ceil");
    check("cnt5", {16'd0, o_sat_cnt}, 32'd5);
    check("ceil_cnt2", {30'd0, o_sat_cnt2}, 32'd3);

    // Clear coinciding with a saturated handshake: the event wins.
    o_ready = 1'b0;
    send(16'h7FFF);
    base = 0;
    while (!o_valid && base < 20) begin step(); base++; end
    check("clr_stall_valid", {31'd0, o_valid}, 32'd1);
    i_clr = 1'b1; o_ready = 1'b1;
    step();
    i_clr = 1'b0;
    check("clr_evt_flag", {31'd0, o_sat_flag}, 32'd1);
    check("clr_evt_cnt", {16'd0, o_sat_cnt}, 32'd1);
    check("clr_evt_cnt2", {30'd0, o_sat_cnt2}, 32'd1);
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    check("clr_flag", {31'd0, o_sat_flag}, 32'd0);
    check("clr_cnt", {16'd0, o_sat_cnt}, 32'd0);

    // Backpressure: continuous stream with a 5-cycle output stall.
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 16; i++) send(16'h0010 + 16'(i));
      end
      begin
        repeat (4) step();
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #2;
          check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
          check("bp_hold_data", {20'd0, o_data}, {20'd0, sb_q[0].data});
          check("bp_iready_low", {31'd0, i_ready}, 32'd0);
          step();
        end
        check("bp_buffered", sb_q.size(), 32'd2);
        o_ready = 1'b1;
        #1;
        check("bp_iready_rise", {31'd0, i_ready}, 32'd1);
      end
    join
    drain("drain_bp");
    check("bp_count", out_cnt - base, 32'd16);

    // Reset mid-stream with two samples in flight.
    send(16'h8000);
    drain("drain_pre_rst");
    check("pre_rst_flag", {31'd0, o_sat_flag}, 32'd1);
    o_ready = 1'b0;
    send(16'h7FFF); send(16'h0010);
    check("inflight_valid", {31'd0, o_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("rst_mid_valid", {31'd0, o_valid}, 32'd0);
    check("rst_mid_flag", {31'd0, o_sat_flag}, 32'd0);
    check("rst_mid_cnt", {16'd0, o_sat_cnt}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rst_no_stale", {31'd0, o_valid}, 32'd0);
      check("rst_iready", {31'd0, i_ready}, 32'd1);
    end
    send(16'h0006);
    drain("drain_post_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
